// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM encoding,
// the latched request record and the access-size helper.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] wdata;
    } lsu_req_t;

    // Access size in bytes; the unsigned variants share the low two bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational data path: load extraction with sign/zero extension and
// store merge of the low N bytes over a read-back doubleword.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] rd_data,
    input  logic [63:0] wdata,
    output logic [63:0] ld_data,
    output logic [63:0] st_data
);

    logic [3:0] nbytes;
    logic       sext;

    assign nbytes = size_bytes(funct3);
    assign sext   = ~funct3[2];

    always_comb begin
        ld_data = rd_data;
        case (funct3[1:0])
            2'b00:   ld_data = {{56{sext & rd_data[7]}},  rd_data[7:0]};
            2'b01:   ld_data = {{48{sext & rd_data[15]}}, rd_data[15:0]};
            2'b10:   ld_data = {{32{sext & rd_data[31]}}, rd_data[31:0]};
            default: ld_data = rd_data;
        endcase
    end

    // Bytes below the access size come from the store data, the rest are kept.
    for (genvar i = 0; i < 8; i++) begin : g_merge
        assign st_data[8*i +: 8] = (4'(i) < nbytes) ? wdata[8*i +: 8] : rd_data[8*i +: 8];
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a 64-bit byte-addressed memory.
// Optional LSU_MISALIGN_TRAP_EN turns size-misaligned accesses into errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1234,
    parameter int XLEN      = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] Mem_Addr,
    output logic [XLEN-1:0] Write_Data,
    output logic            MemWrite,
    output logic            MemRead,
    input  logic [XLEN-1:0] Read_Data
);

    state_t      state, state_nxt;
    lsu_req_t    req_q;
    logic [63:0] data_q;
    logic        err_q;

    logic        accept;
    logic        req_illegal;
    logic        out_of_range;
    logic        misaligned;
    logic        req_err;
    logic [64:0] addr_last;
    logic [63:0] ld_data;
    logic [63:0] st_data;

    // One extra bit so addresses near 2^64 cannot wrap into range.
    assign addr_last    = {1'b0, req_addr} + 65'd7;
    assign out_of_range = addr_last >= 65'(MEM_BYTES);
    assign req_illegal  = (req_funct3 == F3_ILL) || (req_write && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic [3:0] size_m1;
    assign size_m1    = size_bytes(req_funct3) - 4'd1;
    assign misaligned = |(req_addr[2:0] & size_m1[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = req_illegal | out_of_range | misaligned;
    assign accept  = req_valid & req_ready;

    lsu_byte_lane u_lane (
        .funct3  (req_q.funct3),
        .rd_data (Read_Data),
        .wdata   (req_q.wdata),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // data_q holds the store data (raw or merged) or the extended load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    req_q  <= '{write: req_write, funct3: req_funct3,
                               addr: req_addr, wdata: req_wdata};
                    data_q <= req_write ? req_wdata : '0;
                    err_q  <= req_err;
                end
                ST_RD:   data_q <= req_q.write ? st_data : ld_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Mem_Addr   = '0;
        Write_Data = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                                state_nxt = ST_RESP;
                    else if (req_write && req_funct3 == F3_D)   state_nxt = ST_WR;
                    else                                        state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                MemRead   = 1'b1;
                Mem_Addr  = req_q.addr;
                state_nxt = req_q.write ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                MemWrite   = 1'b1;
                Mem_Addr   = req_q.addr;
                Write_Data = data_q;
                state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (req_q.write || err_q) ? '0 : data_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Gating by reset means a reset landing in WR never commits the write.
        if (reset) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_rdata = '0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            Mem_Addr   = '0;
            Write_Data = '0;
        end
    end

endmodule
